// File: rtl/tans_hf_pkg.sv
// Shared constants and tables for the 8-state tANS code wrapped around the 3-symbol Huffman code.
// Tables are pure functions so both decoder and future encoder blocks evaluate them combinationally.
package tans_hf_pkg;

  localparam int L    = 8;
  localparam int X_W  = 4;
  localparam int XS_W = X_W - 1;

  typedef enum logic [1:0] {A = 2'd0, B = 2'd1, C = 2'd2} sym_t;

  typedef enum logic [1:0] {IDLE = 2'd0, SYM = 2'd1, TAIL = 2'd2, DONE = 2'd3} fsm_t;

  function automatic sym_t spread_sym(input logic [2:0] slot);
    sym_t s;
    case (slot)
      3'd0:    s = A;
      3'd1:    s = B;
      3'd2:    s = A;
      3'd3:    s = C;
      3'd4:    s = A;
      3'd5:    s = B;
      3'd6:    s = A;
      default: s = C;
    endcase
    return s;
  endfunction

  function automatic logic [XS_W-1:0] xs_of(input logic [2:0] slot);
    logic [XS_W-1:0] v;
    case (slot)
      3'd0:    v = 3'd4;
      3'd1:    v = 3'd2;
      3'd2:    v = 3'd5;
      3'd3:    v = 3'd2;
      3'd4:    v = 3'd6;
      3'd5:    v = 3'd3;
      3'd6:    v = 3'd7;
      default: v = 3'd3;
    endcase
    return v;
  endfunction

  // nb = 3 - floor(log2 x_s); x_s only spans 2..7 so the top bit decides
  function automatic logic [1:0] nb_of(input logic [XS_W-1:0] x_s);
    return x_s[2] ? 2'd1 : 2'd2;
  endfunction

  // {msb, lsb}; single-bit codes use only the msb position
  function automatic logic [1:0] code_of(input sym_t s);
    logic [1:0] c;
    case (s)
      A:       c = 2'b00;
      B:       c = 2'b10;
      default: c = 2'b11;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] len_of(input sym_t s);
    return (s == A) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/tans_dec_table.sv
// Combinational tANS decode lookup: state x (8..15) -> symbol, bits to read, and x_s base.
// Zero latency; no flow control.
module tans_dec_table
  import tans_hf_pkg::*;
(
  input  logic [X_W-1:0]  x,
  output sym_t            sym,
  output logic [1:0]      nb,
  output logic [XS_W-1:0] x_s
);

  logic [2:0] slot;

  assign slot = 3'(x - X_W'(L));
  assign sym  = spread_sym(slot);
  assign x_s  = xs_of(slot);
  assign nb   = nb_of(x_s);

endmodule

// File: rtl/tans_hf_decoder.sv
// Serial tANS -> Huffman bit regenerator; first bit one cycle after I_F, one bit per cycle.
// Stalls (o_valid low, BTR held) whenever a read is requested and i_valid is low.
module tans_hf_decoder
  import tans_hf_pkg::*;
#(
  parameter int N_SYM = 8,
  parameter int CNT_W = 8
) (
  input  logic       PHI,
  input  logic       RST,
  input  logic       I_F,
  input  logic [3:0] i_state,
  input  logic       i_valid,
  input  logic [1:0] i_stream,
  output logic [1:0] BTR,
  output logic       o_valid,
  output logic       o_bit,
  output logic       o_done,
  output logic       o_busy
);

  fsm_t             fsm_q, fsm_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sym_t             sym;
  logic [1:0]       nb;
  logic [XS_W-1:0]  x_s;
  logic [1:0]       code;
  logic             last;
  logic [X_W-1:0]   rd_bits;
  logic [X_W-1:0]   new_x;

  tans_dec_table u_table (
    .x   (x_q),
    .sym (sym),
    .nb  (nb),
    .x_s (x_s)
  );

  assign code    = code_of(sym);
  assign last    = (cnt_q == CNT_W'(N_SYM - 1));
  assign rd_bits = (nb == 2'd1) ? {{(X_W-1){1'b0}}, i_stream[0]}
                                : {{(X_W-2){1'b0}}, i_stream};
  assign new_x   = ({1'b0, x_s} << nb) | rd_bits;

  always_ff @(posedge PHI) begin
    if (RST) begin
      fsm_q <= IDLE;
      x_q   <= X_W'(L);
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      x_q   <= x_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    BTR     = 2'd0;
    o_valid = 1'b0;
    o_bit   = 1'b0;
    o_done  = 1'b0;
    o_busy  = 1'b0;

    case (fsm_q)
      SYM: begin
        o_busy = 1'b1;
        o_bit  = code[1];
        if (len_of(sym) == 2'd2) begin
          fsm_d = TAIL;
        end else if (last) begin
          fsm_d = DONE;
        end else begin
          BTR = nb;
          if (i_valid) begin
            x_d   = new_x;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        o_valid = (BTR == 2'd0) || i_valid;
      end
      TAIL: begin
        o_busy = 1'b1;
        o_bit  = code[0];
        if (last) begin
          fsm_d = DONE;
        end else begin
          BTR = nb;
          if (i_valid) begin
            x_d   = new_x;
            cnt_d = cnt_q + CNT_W'(1);
            fsm_d = SYM;
          end
        end
        o_valid = (BTR == 2'd0) || i_valid;
      end
      DONE: begin
        o_done = 1'b1;
        fsm_d  = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

    // A new frame overrides whatever the FSM was doing; out-of-range states are folded into 8..15
    if (I_F) begin
      fsm_d = SYM;
      x_d   = i_state | 4'h8;
      cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_tans_hf_decoder.sv
// Drives three decoder instances (N_SYM = 1, 3, 8) from a tANS encoder model and checks the Huffman bits.
module tb_tans_hf_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_f      [3];
  logic [3:0] i_state  [3];
  logic       i_valid  [3];
  logic [1:0] i_stream [3];
  logic [1:0] btr      [3];
  logic       o_valid  [3];
  logic       o_bit    [3];
  logic       o_done   [3];
  logic       o_busy   [3];

  int checks   = 0;
  int failures = 0;
  int msg [8];

  int spread_t [8] = '{0, 1, 0, 2, 0, 1, 0, 2};
  int xs_t     [8] = '{4, 2, 5, 2, 6, 3, 7, 3};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tans_hf_decoder #(
      .N_SYM ((g == 0) ? 1 : (g == 1) ? 3 : 8),
      .CNT_W (8)
    ) u_dut (
      .PHI      (clk),
      .RST      (rst),
      .I_F      (i_f[g]),
      .i_state  (i_state[g]),
      .i_valid  (i_valid[g]),
      .i_stream (i_stream[g]),
      .BTR      (btr[g]),
      .o_valid  (o_valid[g]),
      .o_bit    (o_bit[g]),
      .o_done   (o_done[g]),
      .o_busy   (o_busy[g])
    );
  end

  function automatic int ns(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 8;
  endfunction

  // {o_valid, masked o_bit, BTR, o_done, o_busy}
  function automatic logic [5:0] obs(input int g);
    return {o_valid[g], o_bit[g] & o_valid[g], btr[g], o_done[g], o_busy[g]};
  endfunction

  function automatic int pick_state(input int sym);
    int cand[$];
    for (int t = 0; t < 8; t++) if (spread_t[t] == sym) cand.push_back(8 + t);
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Encode msg backwards from last_x, then feed the decoder and expect the forward Huffman bits.
  // stall_mode: 0 never stall, 1 random i_valid, 2 three stalls at the first read.
  task automatic run_frame(input int g, input int stall_mode, input int abort_after,
                           input bit drop_msb, input int last_x);
    int n, x, nb, s, stalls, emitted;
    int cw [8];
    int cb [8];
    bit qb [$];
    int qw [$];
    int qd [$];
    bit v, ev;
    n = ns(g);
    x = last_x;
    for (int k = 0; k < 8; k++) begin cw[k] = 0; cb[k] = 0; end
    for (int k = n - 2; k >= 0; k--) begin
      nb = (msg[k] == 0) ? 1 : 2;
      cb[k] = x & ((1 << nb) - 1);
      cw[k] = nb;
      s = 0;
      for (int t = 0; t < 8; t++) if (spread_t[t] == msg[k] && xs_t[t] == (x >> nb)) s = t;
      x = 8 + s;
    end
    for (int k = 0; k < n; k++) begin
      if (msg[k] == 0) begin
        qb.push_back(1'b0); qw.push_back((k < n - 1) ? cw[k] : 0); qd.push_back(cb[k]);
      end else begin
        qb.push_back(1'b1); qw.push_back(0); qd.push_back(0);
        qb.push_back(msg[k] == 2); qw.push_back((k < n - 1) ? cw[k] : 0); qd.push_back(cb[k]);
      end
    end

    i_f[g]     = 1'b1;
    i_state[g] = drop_msb ? 4'(x & 7) : 4'(x);
    i_valid[g] = 1'b0;
    @(negedge clk);
    i_f[g]  = 1'b0;
    stalls  = 3;
    emitted = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (emitted == abort_after) return;
      if (qb.size() == 0) begin
        #1 check($sformatf("g%0d done", g), obs(g), 6'b000010);
        @(negedge clk);
        #1 check($sformatf("g%0d idle", g), obs(g), 6'b000000);
        return;
      end
      case (stall_mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 3) != 0);
        default: v = !(qw[0] != 0 && stalls > 0);
      endcase
      if (stall_mode == 2 && !v) stalls--;
      i_valid[g]  = v;
      i_stream[g] = 2'(qd[0]) | ((qw[0] == 1) ? 2'($urandom_range(0, 1) << 1) : 2'b00);
      #1;
      ev = (qw[0] == 0) || v;
      check($sformatf("g%0d bit%0d", g, emitted), obs(g),
            {ev, qb[0] & ev, 2'(qw[0]), 1'b0, 1'b1});
      if (ev) begin
        void'(qb.pop_front()); void'(qw.pop_front()); void'(qd.pop_front());
        emitted++;
      end
      @(negedge clk);
    end
    check($sformatf("g%0d timeout", g), qb.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      i_f[g] = 1'b0; i_state[g] = 4'd0; i_valid[g] = 1'b0; i_stream[g] = 2'd0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("g%0d reset", g), obs(g), 6'b000000);
    rst = 1'b0;
    @(negedge clk);

    // C,B,A from i_state=11: streams 01 then 10
    msg = '{2, 1, 0, 0, 0, 0, 0, 0};
    run_frame(1, 0, -1, 1'b0, 10);
    run_frame(1, 2, -1, 1'b0, 10);

    // all-A frame pinned at x=8 with zero reads
    msg = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(2, 0, -1, 1'b0, 8);

    // abort after two bits, restart with i_state=8
    msg = '{2, 1, 0, 0, 0, 0, 0, 0};
    run_frame(1, 0, 2, 1'b0, 10);
    msg = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(1, 0, -1, 1'b0, 8);

    // reset in the middle of a frame
    msg = '{0, 2, 1, 0, 0, 0, 1, 0};
    run_frame(2, 1, 3, 1'b0, pick_state(msg[7]));
    rst = 1'b1;
    @(negedge clk);
    #1 check("rst mid-frame", obs(2), 6'b000000);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("post-rst idle%0d", i), obs(2), 6'b000000);
    end

    // loopback message A C B A A A B A
    msg = '{0, 2, 1, 0, 0, 0, 1, 0};
    run_frame(2, 0, -1, 1'b0, pick_state(msg[7]));

    // single-symbol frames, including an out-of-range i_state
    for (int s = 0; s < 3; s++) begin
      msg[0] = s;
      run_frame(0, 1, -1, (s == 2), pick_state(s));
    end

    for (int r = 0; r < 30; r++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int k = 0; k < 8; k++) msg[k] = $urandom_range(0, 2);
      run_frame(g, 1, -1, 1'($urandom_range(0, 1)), pick_state(msg[ns(g) - 1]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
